// File: rtl/mini_riscv_decoder.sv
// Decode stage for the mini RISC-V core: ADD/SUB/AND/OR/ADDI/BEQ decode feeding a
// two-entry elastic buffer (output reg + skid reg) with valid/ready on both sides.
module mini_riscv_decoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [1:0]       out_kind,
  output logic [1:0]       out_alu_op,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [31:0]      out_imm,
  output logic             out_we,
  output logic [31:0]      out_br_target,
  output logic [CNT_W-1:0] decoded_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [1:0] KindR   = 2'd0;
  localparam logic [1:0] KindI   = 2'd1;
  localparam logic [1:0] KindB   = 2'd2;
  localparam logic [1:0] KindIll = 2'd3;

  localparam logic [1:0] AluAdd = 2'd0;
  localparam logic [1:0] AluSub = 2'd1;
  localparam logic [1:0] AluAnd = 2'd2;
  localparam logic [1:0] AluOr  = 2'd3;

  localparam logic [6:0] OpReg    = 7'h33;
  localparam logic [6:0] OpImm    = 7'h13;
  localparam logic [6:0] OpBranch = 7'h63;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  kind;
    logic [1:0]  alu_op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        we;
    logic [31:0] br_target;
  } entry_t;

  entry_t           dec;
  entry_t           out_d, out_q;
  entry_t           skid_d, skid_q;
  logic             out_valid_d, out_valid_q;
  logic             skid_valid_d, skid_valid_q;
  logic [CNT_W-1:0] dec_cnt_d, dec_cnt_q;
  logic [CNT_W-1:0] ill_cnt_d, ill_cnt_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_r, is_i, is_b;
  logic [1:0] r_op;
  logic       accept, out_hs;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  always_comb begin
    is_r = 1'b0;
    r_op = AluAdd;
    if (opcode == OpReg) begin
      case ({funct7, funct3})
        {7'h00, 3'b000}: begin is_r = 1'b1; r_op = AluAdd; end
        {7'h20, 3'b000}: begin is_r = 1'b1; r_op = AluSub; end
        {7'h00, 3'b110}: begin is_r = 1'b1; r_op = AluOr;  end
        {7'h00, 3'b111}: begin is_r = 1'b1; r_op = AluAnd; end
        default:         begin is_r = 1'b0; r_op = AluAdd; end
      endcase
    end
    is_i = (opcode == OpImm) && (funct3 == 3'b000);
    is_b = (opcode == OpBranch) && (funct3 == 3'b000);
  end

  // Illegal words keep only their PC; every other field stays zero.
  always_comb begin
    dec      = '0;
    dec.pc   = in_pc;
    dec.kind = KindIll;
    if (is_r) begin
      dec.kind   = KindR;
      dec.alu_op = r_op;
      dec.rd     = in_instr[11:7];
      dec.rs1    = in_instr[19:15];
      dec.rs2    = in_instr[24:20];
    end else if (is_i) begin
      dec.kind   = KindI;
      dec.alu_op = AluAdd;
      dec.rd     = in_instr[11:7];
      dec.rs1    = in_instr[19:15];
      dec.imm    = {{20{in_instr[31]}}, in_instr[31:20]};
    end else if (is_b) begin
      dec.kind   = KindB;
      dec.alu_op = AluSub;
      dec.rs1    = in_instr[19:15];
      dec.rs2    = in_instr[24:20];
      dec.imm    = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
    end
    dec.we        = (is_r || is_i) && (dec.rd != 5'd0);
    dec.br_target = in_pc + dec.imm;
  end

  assign in_ready = !skid_valid_q && !reset;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    dec_cnt_d    = dec_cnt_q;
    ill_cnt_d    = ill_cnt_q;

    if (out_hs) begin
      if (out_q.kind != KindIll) begin
        if (dec_cnt_q != {CNT_W{1'b1}}) dec_cnt_d = dec_cnt_q + 1'b1;
      end else begin
        if (ill_cnt_q != {CNT_W{1'b1}}) ill_cnt_d = ill_cnt_q + 1'b1;
      end
    end

    // With skid_valid_q set in_ready is low, so no accept can collide with the skid drain.
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_hs && skid_valid_q) begin
      out_d        = skid_q;
      out_valid_d  = 1'b1;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      out_valid_d = accept;
      if (accept) out_d = dec;
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      dec_cnt_q    <= '0;
      ill_cnt_q    <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      dec_cnt_q    <= dec_cnt_d;
      ill_cnt_q    <= ill_cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = out_q.pc;
  assign out_kind      = out_q.kind;
  assign out_alu_op    = out_q.alu_op;
  assign out_rd        = out_q.rd;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_imm       = out_q.imm;
  assign out_we        = out_q.we;
  assign out_br_target = out_q.br_target;
  assign decoded_cnt   = dec_cnt_q;
  assign illegal_cnt   = ill_cnt_q;

endmodule

// File: tb/tb_mini_riscv_decoder.sv
// Scoreboard bench for mini_riscv_decoder: directed words push hand-computed entries,
// a negedge monitor pops and compares on every output handshake.
module tb_mini_riscv_decoder;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, flush, out_valid, out_ready, out_we;
  logic [31:0]      in_instr, in_pc, out_pc, out_imm, out_br_target;
  logic [1:0]       out_kind, out_alu_op;
  logic [4:0]       out_rd, out_rs1, out_rs2;
  logic [CNT_W-1:0] decoded_cnt, illegal_cnt;

  mini_riscv_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_kind(out_kind), .out_alu_op(out_alu_op),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_we(out_we), .out_br_target(out_br_target), .decoded_cnt(decoded_cnt),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  kind;
    logic [1:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        we;
    logic [31:0] br;
  } exp_t;

  exp_t sb[$];
  exp_t mon_act, mon_exp;
  int   total = 0;
  int   bad = 0;
  int   cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [1:0] kind,
                              input logic [1:0] alu, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic we, input logic [31:0] br);
    mk = {pc, kind, alu, rd, rs1, rs2, imm, we, br};
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      mon_act = {out_pc, out_kind, out_alu_op, out_rd, out_rs1, out_rs2, out_imm, out_we,
                 out_br_target};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_entry actual pc=%h kind=%0d required none", out_pc, out_kind);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL entry actual pc=%h k=%0d op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h we=%0d br=%h required pc=%h k=%0d op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h we=%0d br=%h",
                   mon_act.pc, mon_act.kind, mon_act.alu, mon_act.rd, mon_act.rs1, mon_act.rs2,
                   mon_act.imm, mon_act.we, mon_act.br, mon_exp.pc, mon_exp.kind, mon_exp.alu,
                   mon_exp.rd, mon_exp.rs1, mon_exp.rs2, mon_exp.imm, mon_exp.we, mon_exp.br);
        end
      end
    end
  end

  // Offers one word until accepted (bounded); expected entry enters the scoreboard on accept.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e,
                      output int cycles);
    logic acc;
    acc      = 1'b0;
    cycles   = 0;
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
    while (!acc && cycles < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cycles++;
    end
    in_valid = 1'b0;
    if (acc) sb.push_back(e);
    else begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=not_accepted required=accepted pc=%h", pc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    idle(2);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_dec_cnt", 64'(decoded_cnt), 64'd0);
    chk("rst_ill_cnt", 64'(illegal_cnt), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // ADDI x1,x0,5
    send(32'h00500093, 32'h0, mk(32'h0, 2'd1, 2'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h5), cyc);
    chk("addi_latency", {63'd0, out_valid}, 64'd1);
    idle(1);
    chk("addi_dec_cnt", 64'(decoded_cnt), 64'd1);

    // SUB x4,x2,x1 then AND x5,x1,x2 back to back
    send(32'h40110233, 32'h4, mk(32'h4, 2'd0, 2'd1, 5'd4, 5'd2, 5'd1, 32'd0, 1'b1, 32'h4), cyc);
    send(32'h0020F2B3, 32'h8, mk(32'h8, 2'd0, 2'd2, 5'd5, 5'd1, 5'd2, 32'd0, 1'b1, 32'h8), cyc);
    chk("and_throughput", 64'(cyc), 64'd1);

    // BEQ +8 and BEQ -4
    send(32'h00000463, 32'h18,
         mk(32'h18, 2'd2, 2'd1, 5'd0, 5'd0, 5'd0, 32'd8, 1'b0, 32'h20), cyc);
    send(32'hFE000EE3, 32'h20,
         mk(32'h20, 2'd2, 2'd1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0, 32'h1C), cyc);

    // illegal SLL, then ADDI x0,x0,1
    send(32'h00001033, 32'h24, mk(32'h24, 2'd3, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'h24), cyc);
    send(32'h00100013, 32'h28, mk(32'h28, 2'd1, 2'd0, 5'd0, 5'd0, 5'd0, 32'd1, 1'b0, 32'h29), cyc);
    idle(3);
    chk("phase1_dec_cnt", 64'(decoded_cnt), 64'd6);
    chk("phase1_ill_cnt", 64'(illegal_cnt), 64'd1);

    // Backpressure: ADD x3,x1,x2 / OR x6,x3,x4 / ADDI x7,x7,-1
    out_ready = 1'b0;
    send(32'h002081B3, 32'h40, mk(32'h40, 2'd0, 2'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h40), cyc);
    send(32'h0041E333, 32'h44, mk(32'h44, 2'd0, 2'd3, 5'd6, 5'd3, 5'd4, 32'd0, 1'b1, 32'h44), cyc);
    chk("bp_skid_accept", 64'(cyc), 64'd1);
    chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("bp_held_pc", 64'(out_pc), 64'h40);
    fork
      send(32'hFFF38393, 32'h48,
           mk(32'h48, 2'd1, 2'd0, 5'd7, 5'd7, 5'd0, 32'hFFFFFFFF, 1'b1, 32'h47), cyc);
      begin
        idle(3);
        out_ready = 1'b1;
      end
    join
    chk("bp_third_wait", 64'(cyc), 64'd5);
    idle(3);
    chk("bp_dec_cnt", 64'(decoded_cnt), 64'd9);

    // Flush with two entries buffered and a word offered
    out_ready = 1'b0;
    send(32'h002081B3, 32'h60, mk(32'h60, 2'd0, 2'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h60), cyc);
    send(32'h0041E333, 32'h64, mk(32'h64, 2'd0, 2'd3, 5'd6, 5'd3, 5'd4, 32'd0, 1'b1, 32'h64), cyc);
    in_instr = 32'h00500093; in_pc = 32'h68; in_valid = 1'b1; flush = 1'b1;
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_dec_cnt", 64'(decoded_cnt), 64'd9);
    chk("flush_ill_cnt", 64'(illegal_cnt), 64'd1);
    // Word accepted in the flush cycle is dropped
    in_valid = 1'b1; flush = 1'b1;
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop_accept", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    send(32'h00500093, 32'h70, mk(32'h70, 2'd1, 2'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h75), cyc);
    idle(3);
    chk("post_flush_dec_cnt", 64'(decoded_cnt), 64'd10);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // Reset mid-stream
    out_ready = 1'b0;
    send(32'h40110233, 32'h80, mk(32'h80, 2'd0, 2'd1, 5'd4, 5'd2, 5'd1, 32'd0, 1'b1, 32'h80), cyc);
    send(32'h0020F2B3, 32'h84, mk(32'h84, 2'd0, 2'd2, 5'd5, 5'd1, 5'd2, 32'd0, 1'b1, 32'h84), cyc);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    idle(1);
    sb.delete();
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_fields", {out_pc, out_imm}, 64'd0);
    chk("mid_rst_misc", {31'd0, out_br_target, out_we}, 64'd0);
    chk("mid_rst_codes", {45'd0, out_kind, out_alu_op, out_rd, out_rs1, out_rs2}, 64'd0);
    chk("mid_rst_cnts", {32'd0, decoded_cnt, illegal_cnt}, 64'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    idle(3);
    chk("post_mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_mid_rst_out_valid", {63'd0, out_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mini_riscv_decoder.md
Name: mini_riscv_decoder

Overview:
Instruction decode stage for the mini RISC-V core. It takes fetched 32-bit instruction words tagged with their PC and unpacks the R/I/B subset the core supports: ADD, SUB, AND, OR, ADDI and BEQ. Outputs are register fields, sign-extended immediate, ALU op and branch target. Both sides use valid/ready handshakes, with a skid buffer so either side can stall without dropping words.

Parameters:
CNT_W, 16, width of the decoded and illegal instruction counters (saturating)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  decoder can accept; equals !skid_valid && !reset
in_instr  input  32  instruction word
in_pc  input  32  byte address of in_instr
flush  input  1  synchronous discard of all buffered/output entries
out_valid  output  1  decoded entry valid
out_ready  input  1  downstream accepts entry
out_pc  output  32  PC of decoded entry
out_kind  output  2  0=R, 1=I, 2=B, 3=illegal
out_alu_op  output  2  0=ADD, 1=SUB, 2=AND, 3=OR
out_rd  output  5  destination register
out_rs1  output  5  source 1
out_rs2  output  5  source 2
out_imm  output  32  sign-extended immediate
out_we  output  1  register write enable
out_br_target  output  32  out_pc + out_imm, mod 2^32
decoded_cnt  output  CNT_W  legal entries handed off
illegal_cnt  output  CNT_W  illegal entries handed off

Behaviour:
- Reset (synchronous, highest priority): out_valid, skid_valid, all out_* fields and both counters go to 0. in_ready is 0 during reset and 1 in the first cycle after.
- Accept: in_valid && in_ready. Decode is purely combinational from the word; the result is registered.
- Latency: 1 cycle, accept edge to out_valid.
- Two-entry elastic buffer (output reg plus skid reg):
  - Accept when the output is empty or being consumed this cycle: data goes to the output reg.
  - Accept while the output is held (out_valid && !out_ready): data goes to the skid reg, and in_ready drops the next cycle.
  - On output handshake with skid_valid set: skid moves to output, skid clears.
  - Order is strictly preserved. No entry is lost or duplicated.
  - Full throughput of 1 per cycle when out_ready is held at 1.
- Output fields stay stable while out_valid && !out_ready.
- Decode rules (any other encoding is illegal):
  - opcode 0x33, funct3 000, funct7 0x00 -> R, ADD.
  - opcode 0x33, funct3 000, funct7 0x20 -> R, SUB.
  - opcode 0x33, funct3 110, funct7 0x00 -> R, OR.
  - opcode 0x33, funct3 111, funct7 0x00 -> R, AND.
  - opcode 0x13, funct3 000 -> I, ADD (ADDI). imm = sign-extend instr[31:20]. rs2 = 0.
  - opcode 0x63, funct3 000 -> B (BEQ), alu_op SUB. imm = sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}. rd = 0.
  - R-type: imm = 0.
- out_we = 1 for R/I with rd != 0; 0 for rd == x0, B and illegal.
- Illegal entries: kind = 3, pc preserved, all other fields 0 (br_target = pc). They still flow through the handshake and are not dropped.
- Counters:
  - On each output handshake, decoded_cnt increments if kind != 3, otherwise illegal_cnt increments.
  - Both saturate at all-ones.
  - flush does not clear them.
- Flush:
  - Clears out_valid and skid_valid at the edge.
  - A word accepted in the flush cycle is discarded.
  - A handshake in the flush cycle still counts.
  - in_ready = 1 the next cycle.
  - Priority: reset > flush > normal.
- Reset mid-stream discards every entry, with no partial output.

Test Plan:
- ADDI x1,x0,5 (0x00500093) at pc 0x00, out_ready=1 -> next cycle: kind=1, alu_op=0, rd=1, rs1=0, imm=5, we=1; decoded_cnt=1.
- SUB x4,x2,x1 (0x40110233), then AND x5,x1,x2 (0x0020F2B3) back to back -> consecutive cycles: kind=0, alu_op=1, rd=4, rs1=2, rs2=1, then alu_op=2, rd=5; imm=0, we=1.
- BEQ x0,x0,+8 (0x00000463) at pc 0x18 -> kind=2, imm=8, br_target=0x20, we=0. BEQ -4 (0xFE000EE3) at pc 0x20 -> imm=0xFFFFFFFC, br_target=0x1C.
- Illegal SLL (0x00001033) and ADDI x0,x0,1 (0x00100013) -> first: kind=3, all fields 0, illegal_cnt=1. Second: kind=1, we=0.
- Backpressure: out_ready=0 while offering 3 instructions -> 2 accepted, in_ready=0 from the cycle after the 2nd accept. Raising out_ready drains them in order, then the 3rd is accepted. No loss or duplication.
- Flush with 2 entries buffered and in_valid=1 -> next cycle out_valid=0, in_ready=1, counters unchanged. Reset asserted mid-stream -> all outputs and counters 0.
